// File: rtl/kmeans_iter_ctrl.sv
// Lloyd's-algorithm iteration controller: streams points through the assignment datapath,
// accumulates per-cluster sums, divides to new centroids. Optional macro: KMEANS_TOL_EN.
module kmeans_iter_ctrl #(
  parameter int unsigned AW       = 10,
  parameter int unsigned MAX_ITER = 16,
  parameter logic [15:0] TOL      = 16'h0010
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] num_points,
  input  logic [47:0]   init_cx,
  input  logic [47:0]   init_cy,
  output logic          pt_rd_en,
  output logic [AW-1:0] pt_rd_addr,
  input  logic [31:0]   pt_rd_data,
  output logic          dp_valid,
  output logic [15:0]   dp_x,
  output logic [15:0]   dp_y,
  input  logic          dp_result_valid,
  input  logic [1:0]    dp_cluster,
  output logic [47:0]   cent_x,
  output logic [47:0]   cent_y,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [4:0]    iter_count
);

  localparam int unsigned DW = 16 + AW;
  localparam int unsigned BW = $clog2(DW);
  localparam logic [BW-1:0] BitLast = BW'(DW - 1);
  localparam logic [AW-1:0] One     = AW'(1);
  localparam logic [4:0]    MaxIter = 5'(MAX_ITER);
`ifdef KMEANS_TOL_EN
  localparam logic [15:0] Tol = TOL;
`else
  // Exact-match mode is simply a zero tolerance.
  localparam logic [15:0] Tol = TOL & 16'h0000;
`endif

  typedef enum logic [2:0] {
    StIdle, StLoad, StAssign, StDrain, StUpdate, StCheck, StDone
  } state_e;

  state_e                  state_q;
  logic [AW-1:0]           num_q, addr_q, ret_q, ret_d;
  logic                    rd_en_q, dp_valid_q;
  logic [15:0]             pt_x_q, pt_y_q;
  logic [2:0][DW-1:0]      sum_x_q, sum_y_q;
  logic [2:0][AW-1:0]      cnt_q;
  logic [2:0][15:0]        cent_x_q, cent_y_q, new_x_q, new_y_q;
  logic [2:0]              sel_q;
  logic [BW-1:0]           bcnt_q;
  logic [DW-1:0]           dvd_q;
  logic [AW-1:0]           rem_q;
  logic                    busy_q, done_q, conv_q;
  logic [4:0]              iter_q;

  logic                    acc_en;
  logic [1:0]              acc_c, div_c;
  logic [DW-1:0]           div_sum, cur_dvd, dvd_nxt;
  logic [AW-1:0]           div_cnt, cur_rem, rem_nxt;
  logic [AW:0]             trial, diff;
  logic [15:0]             div_old, div_res;
  logic                    all_close;

  function automatic logic close_enough(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return d <= Tol;
  endfunction

  assign acc_en = dp_result_valid && (state_q == StAssign || state_q == StDrain);
  assign acc_c  = dp_cluster - 2'd1;
  assign ret_d  = acc_en ? ret_q + One : ret_q;

  // Restoring divider step; operands are muxed in on the first bit so the accumulator
  // update landing on the DRAIN->UPDATE edge is still seen.
  always_comb begin
    div_c   = sel_q[2:1];
    div_sum = sel_q[0] ? sum_y_q[div_c] : sum_x_q[div_c];
    div_old = sel_q[0] ? cent_y_q[div_c] : cent_x_q[div_c];
    div_cnt = cnt_q[div_c];
    cur_dvd = (bcnt_q == '0) ? div_sum : dvd_q;
    cur_rem = (bcnt_q == '0) ? '0 : rem_q;
    trial   = {cur_rem, cur_dvd[DW-1]};
    // rem < divisor keeps trial < 2*divisor, so the diff MSB is exactly the borrow.
    diff    = trial - {1'b0, div_cnt};
    dvd_nxt = {cur_dvd[DW-2:0], ~diff[AW]};
    rem_nxt = diff[AW] ? trial[AW-1:0] : diff[AW-1:0];
    div_res = (div_cnt == '0) ? div_old : dvd_nxt[15:0];
  end

  always_comb begin
    all_close = 1'b1;
    for (int c = 0; c < 3; c++) begin
      all_close = all_close & close_enough(new_x_q[c], cent_x_q[c])
                            & close_enough(new_y_q[c], cent_y_q[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      num_q      <= '0;
      addr_q     <= '0;
      ret_q      <= '0;
      rd_en_q    <= 1'b0;
      dp_valid_q <= 1'b0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      cnt_q      <= '0;
      cent_x_q   <= '0;
      cent_y_q   <= '0;
      new_x_q    <= '0;
      new_y_q    <= '0;
      sel_q      <= '0;
      bcnt_q     <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_q     <= 1'b0;
      iter_q     <= '0;
    end else begin
      // Second stage of the point delay line (memory output register is the first).
      dp_valid_q <= rd_en_q;
      pt_x_q     <= pt_rd_data[31:16];
      pt_y_q     <= pt_rd_data[15:0];
      done_q     <= 1'b0;
      ret_q      <= ret_d;
      if (acc_en && dp_cluster != 2'd0) begin
        sum_x_q[acc_c] <= sum_x_q[acc_c] + {{AW{1'b0}}, pt_x_q};
        sum_y_q[acc_c] <= sum_y_q[acc_c] + {{AW{1'b0}}, pt_y_q};
        cnt_q[acc_c]   <= cnt_q[acc_c] + One;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_q    <= num_points;
            cent_x_q <= init_cx;
            cent_y_q <= init_cy;
            iter_q   <= '0;
            conv_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          sum_x_q <= '0;
          sum_y_q <= '0;
          cnt_q   <= '0;
          ret_q   <= '0;
          if (num_q == '0) begin
            conv_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            rd_en_q <= 1'b1;
            addr_q  <= '0;
            state_q <= StAssign;
          end
        end
        StAssign: begin
          if (addr_q == num_q - One) begin
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            addr_q <= addr_q + One;
          end
        end
        StDrain: begin
          if (ret_d == num_q) begin
            sel_q   <= '0;
            bcnt_q  <= '0;
            state_q <= StUpdate;
          end
        end
        StUpdate: begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          if (bcnt_q == BitLast) begin
            bcnt_q <= '0;
            if (sel_q[0]) new_y_q[div_c] <= div_res;
            else          new_x_q[div_c] <= div_res;
            if (sel_q == 3'd5) state_q <= StCheck;
            else               sel_q   <= sel_q + 3'd1;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        StCheck: begin
          cent_x_q <= new_x_q;
          cent_y_q <= new_y_q;
          iter_q   <= iter_q + 5'd1;
          conv_q   <= all_close;
          if (all_close || (iter_q + 5'd1) == MaxIter) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StLoad;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pt_rd_en   = rd_en_q;
  assign pt_rd_addr = addr_q;
  assign dp_valid   = dp_valid_q;
  assign dp_x       = pt_rd_data[31:16];
  assign dp_y       = pt_rd_data[15:0];
  assign cent_x     = cent_x_q;
  assign cent_y     = cent_y_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Scoreboard bench for kmeans_iter_ctrl: directed point sets, a registered argmin datapath
// model, and a done-triggered monitor comparing result, iteration count and latency.
module tb_kmeans_iter_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16 + AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] num_points = '0;
  logic [47:0]   init_cx = '0, init_cy = '0;
  logic          start_a = 1'b0, start_b = 1'b0;

  logic          rd_en_a, rd_en_b, dpv_a, dpv_b, busy_a, busy_b, done_a, done_b;
  logic          conv_a, conv_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [31:0]   rd_data_a = '0, rd_data_b = '0;
  logic [15:0]   dpx_a, dpy_a, dpx_b, dpy_b;
  logic          rv_a = 1'b0, rv_b = 1'b0;
  logic [1:0]    cl_a = '0, cl_b = '0;
  logic [47:0]   cx_a, cy_a, cx_b, cy_b;
  logic [4:0]    iter_a, iter_b;

  kmeans_iter_ctrl #(.AW(AW), .MAX_ITER(16), .TOL(16'h0010)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_points(num_points),
    .init_cx(init_cx), .init_cy(init_cy), .pt_rd_en(rd_en_a), .pt_rd_addr(rd_addr_a),
    .pt_rd_data(rd_data_a), .dp_valid(dpv_a), .dp_x(dpx_a), .dp_y(dpy_a),
    .dp_result_valid(rv_a), .dp_cluster(cl_a), .cent_x(cx_a), .cent_y(cy_a),
    .busy(busy_a), .done(done_a), .converged(conv_a), .iter_count(iter_a)
  );

  kmeans_iter_ctrl #(.AW(AW), .MAX_ITER(1), .TOL(16'h0010)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_points(num_points),
    .init_cx(init_cx), .init_cy(init_cy), .pt_rd_en(rd_en_b), .pt_rd_addr(rd_addr_b),
    .pt_rd_data(rd_data_b), .dp_valid(dpv_b), .dp_x(dpx_b), .dp_y(dpy_b),
    .dp_result_valid(rv_b), .dp_cluster(cl_b), .cent_x(cx_b), .cent_y(cy_b),
    .busy(busy_b), .done(done_b), .converged(conv_b), .iter_count(iter_b)
  );

  // Squared-distance argmin; strict less-than so the lowest id wins ties.
  function automatic logic [1:0] nearest(input logic [15:0] x, input logic [15:0] y,
                                         input logic [47:0] cx, input logic [47:0] cy);
    logic [33:0] dx, dy, d, best;
    logic [15:0] ccx, ccy;
    logic [1:0]  id;
    best = '1;
    id   = 2'd1;
    for (int c = 0; c < 3; c++) begin
      ccx = cx[16*c +: 16];
      ccy = cy[16*c +: 16];
      dx  = {18'd0, (x >= ccx) ? x - ccx : ccx - x};
      dy  = {18'd0, (y >= ccy) ? y - ccy : ccy - y};
      d   = dx * dx + dy * dy;
      if (c == 0 || d < best) begin
        best = d;
        id   = 2'(c + 1);
      end
    end
    return id;
  endfunction

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    rv_a <= dpv_a;
    rv_b <= dpv_b;
    cl_a <= nearest(dpx_a, dpy_a, cx_a, cy_a);
    cl_b <= nearest(dpx_b, dpy_b, cx_b, cy_b);
  end

  typedef struct {
    logic        conv;
    logic [4:0]  iter;
    logic [47:0] cx;
    logic [47:0] cy;
    int unsigned lat;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  exp_t        ea, eb;
  int unsigned st_a = 0, st_b = 0;
  int unsigned n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  function automatic int unsigned exp_lat(input int unsigned n, input int unsigned iters);
    return (n == 0) ? 2 : 1 + iters * (n + 4 + 6 * DW);
  endfunction

  function automatic logic [47:0] pk(input logic [15:0] c1, input logic [15:0] c2,
                                     input logic [15:0] c3);
    return {c3, c2, c1};
  endfunction

  task automatic set_pt(input int i, input logic [15:0] x, input logic [15:0] y);
    mem[i] = {x, y};
  endtask

  task automatic launch(input bit b, input int unsigned n, input logic [47:0] icx,
                        input logic [47:0] icy, input logic conv, input logic [4:0] iters,
                        input logic [47:0] ecx, input logic [47:0] ecy);
    exp_t e;
    @(posedge clk);
    #1;
    e.conv = conv; e.iter = iters; e.cx = ecx; e.cy = ecy; e.lat = exp_lat(n, iters);
    num_points = AW'(n);
    init_cx    = icx;
    init_cy    = icy;
    if (b) begin q_b.push_back(e); st_b = cyc; start_b = 1'b1; end
    else   begin q_a.push_back(e); st_a = cyc; start_a = 1'b1; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input bit b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (b ? (!busy_b && q_b.size() == 0) : (!busy_a && q_a.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(b ? "run_b_complete" : "run_a_complete", 64'(ok), 64'd1);
    if (!ok) begin q_a.delete(); q_b.delete(); end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      chk("done_a_expected", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        chk("conv_a", 64'(conv_a), 64'(ea.conv));
        chk("iter_a", 64'(iter_a), 64'(ea.iter));
        chk("cent_x_a", 64'(cx_a), 64'(ea.cx));
        chk("cent_y_a", 64'(cy_a), 64'(ea.cy));
        chk("latency_a", 64'(cyc - st_a), 64'(ea.lat));
      end
    end
    if (done_b) begin
      chk("done_b_expected", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        chk("conv_b", 64'(conv_b), 64'(eb.conv));
        chk("iter_b", 64'(iter_b), 64'(eb.iter));
        chk("cent_x_b", 64'(cx_b), 64'(eb.cx));
        chk("cent_y_b", 64'(cy_b), 64'(eb.cy));
        chk("latency_b", 64'(cyc - st_b), 64'(eb.lat));
      end
    end
  end

  task automatic load_s2();
    set_pt(0, 16'h0100, 16'h0100);
    set_pt(1, 16'h0200, 16'h0200);
    set_pt(2, 16'h0700, 16'h0700);
    set_pt(3, 16'h0900, 16'h0900);
    set_pt(4, 16'h0100, 16'h0900);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_rd_en", 64'(rd_en_a), 64'd0);
    chk("rst_cent_x", 64'(cx_a), 64'd0);
    chk("rst_cent_y", 64'(cy_a), 64'd0);
    chk("rst_iter", 64'(iter_a), 64'd0);
    chk("rst_conv", 64'(conv_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_dp_valid", 64'(dpv_a), 64'd0);
    rst = 1'b0;

    // Already-converged set; a second start mid-run must be ignored.
    set_pt(0, 16'h0100, 16'h0100);
    set_pt(1, 16'h0300, 16'h0300);
    set_pt(2, 16'h0500, 16'h0500);
    set_pt(3, 16'h0700, 16'h0700);
    launch(1'b0, 4, pk(16'h0200, 16'h0600, 16'h0180), pk(16'h0200, 16'h0600, 16'h0800),
           1'b1, 5'd1, pk(16'h0200, 16'h0600, 16'h0180), pk(16'h0200, 16'h0600, 16'h0800));
    repeat (8) @(posedge clk);
    #1;
    chk("busy_during_run", 64'(busy_a), 64'd1);
    num_points = AW'(3);
    init_cx    = '1;
    init_cy    = '1;
    start_a    = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_idle(1'b0);

    // Two iterations to converge.
    load_s2();
    launch(1'b0, 5, pk(16'h0000, 16'h0800, 16'h0000), pk(16'h0000, 16'h0800, 16'h0800),
           1'b1, 5'd2, pk(16'h0180, 16'h0800, 16'h0100), pk(16'h0180, 16'h0800, 16'h0900));
    wait_idle(1'b0);

    // Empty point set.
    launch(1'b0, 0, pk(16'h1111, 16'h2222, 16'h3333), pk(16'h4444, 16'h5555, 16'h6666),
           1'b1, 5'd0, pk(16'h1111, 16'h2222, 16'h3333), pk(16'h4444, 16'h5555, 16'h6666));
    wait_idle(1'b0);

    // Iteration cap of one.
    launch(1'b1, 5, pk(16'h0000, 16'h0800, 16'h0000), pk(16'h0000, 16'h0800, 16'h0800),
           1'b0, 5'd1, pk(16'h0180, 16'h0800, 16'h0100), pk(16'h0180, 16'h0800, 16'h0900));
    wait_idle(1'b1);

    // Floor division, empty c3 keeps its value.
    set_pt(0, 16'h0100, 16'h0100);
    set_pt(1, 16'h0101, 16'h0103);
    set_pt(2, 16'h0900, 16'h0900);
    launch(1'b0, 3, pk(16'h0100, 16'h0800, 16'h4000), pk(16'h0100, 16'h0800, 16'h4000),
           1'b1, 5'd2, pk(16'h0100, 16'h0900, 16'h4000), pk(16'h0101, 16'h0900, 16'h4000));
    wait_idle(1'b0);

    // Reset in the middle of ASSIGN, then a clean rerun.
    load_s2();
    launch(1'b0, 5, pk(16'h0000, 16'h0800, 16'h0000), pk(16'h0000, 16'h0800, 16'h0800),
           1'b1, 5'd2, pk(16'h0180, 16'h0800, 16'h0100), pk(16'h0180, 16'h0800, 16'h0900));
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_en_a) begin ok = 1'b1; break; end
    end
    chk("reached_assign", 64'(ok), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_rd_en", 64'(rd_en_a), 64'd0);
    chk("midrst_cent_x", 64'(cx_a), 64'd0);
    chk("midrst_cent_y", 64'(cy_a), 64'd0);
    q_a.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    launch(1'b0, 5, pk(16'h0000, 16'h0800, 16'h0000), pk(16'h0000, 16'h0800, 16'h0800),
           1'b1, 5'd2, pk(16'h0180, 16'h0800, 16'h0100), pk(16'h0180, 16'h0800, 16'h0900));
    wait_idle(1'b0);

    repeat (3) @(negedge clk);
    chk("sb_a_drained", 64'(q_a.size()), 64'd0);
    chk("sb_b_drained", 64'(q_b.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kmeans_iter_ctrl.md
Name: kmeans_iter_ctrl

Overview:
- Iteration controller for the k-means assignment datapath (three parallel distance units, min-finder, registered cluster output).
- Runs Lloyd's algorithm over a point memory:
  - streams every point through the datapath;
  - accumulates per-cluster coordinate sums and counts;
  - divides to form new centroids;
  - repeats until convergence or an iteration cap.
- Owns the centroid registers that feed the datapath.

Parameters:
- AW, 10, point-memory address width; num_points up to 2^AW-1.
- MAX_ITER, 16, iteration cap (≥1).
- TOL, 16'h0010, per-coordinate convergence tolerance (Q8.8); used only with KMEANS_TOL_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run.
- num_points  in  AW  point count, sampled at start.
- init_cx, init_cy  in  48  initial centroids, packed {c3,c2,c1}, 16-bit unsigned Q8.8; sampled at start.
- pt_rd_en  out  1  point-memory read strobe.
- pt_rd_addr  out  AW  read address.
- pt_rd_data  in  32  {x[31:16], y[15:0]}; valid 1 cycle after pt_rd_en.
- dp_valid  out  1  point presented to datapath.
- dp_x, dp_y  out  16  point coordinates.
- dp_result_valid  in  1  datapath result strobe; 1 cycle after dp_valid.
- dp_cluster  in  2  1=c1, 2=c2, 3=c3.
- cent_x, cent_y  out  48  current centroids {c3,c2,c1} to the distance units.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at run end.
- converged  out  1  valid when done; held until next start.
- iter_count  out  5  completed iterations; held until next start.

Behaviour:
- Reset: every output 0; centroid registers 0; FSM to IDLE. Reset mid-run aborts immediately; no partial results are kept.
- IDLE:
  - start → LOAD; latch num_points, init_cx/cy into cent_x/y; clear iter_count and converged; busy=1 from the next cycle.
  - start while busy is ignored.
- LOAD (1 cycle):
  - clear 3×(sum_x, sum_y, count); sums are 16+AW bits, counts AW bits.
  - num_points==0 → DONE with converged=1, iter_count=0, centroids = init.
  - otherwise → ASSIGN.
- ASSIGN:
  - one read per cycle, addresses 0..num_points-1; no stalls.
  - pt_rd_data is forwarded registered-free as dp_valid/dp_x/dp_y on the following cycle.
  - after the last read issues → DRAIN.
- Accumulation (ASSIGN and DRAIN): on dp_result_valid with dp_cluster=c∈{1,2,3}, add the point coordinates to sum_c and increment count_c. Point coordinates are carried in a 2-deep delay line aligned to the result.
  - dp_cluster=0 (invalid): counted as returned, not accumulated.
  - dp_result_valid in any other state: ignored.
- DRAIN: wait until returned results == num_points → UPDATE.
- UPDATE:
  - for c=1..3, x then y: count_c==0 keeps the old coordinate.
  - otherwise new = floor(sum/count) via internal restoring divider, 1 quotient bit/cycle, 16+AW cycles per divide; quotient truncated to 16 bits.
  - new values go to shadow registers; cent_x/y are unchanged during UPDATE.
- CHECK (1 cycle):
  - converged = all six new == old (exact).
  - commit shadows to cent_x/y; iter_count++.
  - converged or iter_count==MAX_ITER → DONE; else → LOAD (re-clear accumulators, same num_points).
- DONE (1 cycle): done=1, busy=0 next cycle, → IDLE.
- Latency per iteration: 1 (LOAD) + num_points + 2 (pipeline drain) + 6×(16+AW) + 1 (CHECK).

Optional Feature:
- KMEANS_TOL_EN defined: CHECK declares convergence when every |new-old| ≤ TOL (unsigned absolute difference, 16-bit).
- Undefined: exact equality only; TOL unused.

Test Plan:
- Bench datapath model: registered squared-distance argmin, lowest id wins ties.
- Init c1=(0x0200,0x0200), c2=(0x0600,0x0600), c3=(0x0180,0x0800); points (1,1),(3,3),(5,5),(7,7) in Q8.8 → centroids unchanged, converged=1, iter_count=1, one done pulse.
- Init c1=(0,0), c2=(0x0800,0x0800), c3=(0,0x0800); points (1,1),(2,2),(7,7),(9,9),(1,9) → after iteration 1 c1=(0x0180,0x0180), c2=(0x0800,0x0800), c3=(0x0100,0x0900); converged=1, iter_count=2.
- num_points=0 → done 2 cycles after start, converged=1, iter_count=0, cent = init.
- MAX_ITER=1 with the second scenario → done after 1 iteration, converged=0, iter_count=1.
- Floor division: c1 gets points x=0x0100 and x=0x0101 → new x=0x0100; empty c3 keeps its value.
- Assert rst mid-ASSIGN → same cycle busy=0, pt_rd_en=0, cent=0; a fresh start then completes normally. Also check that start while busy has no effect.
